// File: rtl/router_pkg.sv
// Shared types and header-field helpers for the router receive path.
package router_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned DEST_W   = 2;
    localparam int unsigned LEN_W    = 6;
    localparam int unsigned DEST_MSB = 7;
    localparam int unsigned LEN_MSB  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        FORWARD = 2'd2
    } rx_state_t;

    function automatic logic [DEST_W-1:0] hdr_dest(input logic [BYTE_W-1:0] hdr);
        return hdr[DEST_MSB -: DEST_W];
    endfunction

    function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] hdr);
        return hdr[LEN_MSB -: LEN_W];
    endfunction

endpackage

// File: rtl/router_rx_fifo.sv
// Synchronous show-ahead FIFO; the caller guarantees no push when full without pop, and no pop when empty.
module router_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;

    assign count_next = count + CW'(push) - CW'(pop);
    assign head       = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/router_rx_buffer.sv
// Receive buffer: captures DataPort bytes, parses headers and replays packets over valid/accept.
// Optional drop counter port ovf_count is built when RXBUF_OVF_COUNT_EN is defined.
module router_rx_buffer
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] port_data,
    input  logic              port_ready,
    output logic [BYTE_W-1:0] fwd_data,
    output logic              fwd_valid,
    output logic              fwd_sop,
    output logic              fwd_eop,
    output logic [DEST_W-1:0] fwd_dest,
    input  logic              fwd_accept,
    output logic              rx_full,
    output logic              rx_empty,
    output logic              overflow
`ifdef RXBUF_OVF_COUNT_EN
    ,
    output logic [7:0]        ovf_count
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    rx_state_t         state, state_next;
    logic [LEN_W-1:0]  remain, remain_next;
    logic [DEST_W-1:0] dest_q, dest_next;
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic [BYTE_W-1:0] head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              at_cap, push, pop, drop;

    // Input capture stage isolates the unthrottled port bus from FIFO control.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_valid <= 1'b0;
            in_data  <= '0;
        end else begin
            in_valid <= port_ready;
            in_data  <= port_data;
        end
    end

    assign at_cap = (fifo_count == CW'(DEPTH));
    assign pop    = fwd_valid & fwd_accept;
    assign push   = in_valid & (~at_cap | pop);
    assign drop   = in_valid & at_cap & ~pop;

    router_rx_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .head  (head),
        .full  (rx_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rx_empty = fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            remain <= '0;
            dest_q <= '0;
        end else begin
            state  <= state_next;
            remain <= remain_next;
            dest_q <= dest_next;
        end
    end

    always_comb begin
        state_next  = state;
        remain_next = remain;
        dest_next   = dest_q;
        fwd_valid   = 1'b0;
        fwd_sop     = 1'b0;
        fwd_eop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    dest_next   = hdr_dest(head);
                    remain_next = hdr_len(head);
                    state_next  = HEADER;
                end
            end
            HEADER: begin
                fwd_valid = 1'b1;
                fwd_sop   = 1'b1;
                fwd_eop   = (remain == '0);
                if (fwd_accept) state_next = (remain == '0) ? IDLE : FORWARD;
            end
            FORWARD: begin
                fwd_valid = ~fifo_empty;
                fwd_eop   = ~fifo_empty & (remain == LEN_W'(1));
                if (!fifo_empty && fwd_accept) begin
                    remain_next = remain - LEN_W'(1);
                    if (remain == LEN_W'(1)) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fwd_data = fwd_valid ? head : '0;
    assign fwd_dest = (state == IDLE) ? '0 : dest_q;

    // Sticky drop flag; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)     overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef RXBUF_OVF_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)                            ovf_count <= '0;
        else if (drop && ovf_count != 8'hFF)  ovf_count <= ovf_count + 8'd1;
    end
`endif

endmodule
